regfile_dump_uart: RTL

Debug-output block that reads the CPU register file's 176-bit debug snapshot (R0–R7, SP, IH, T) and transmits it over a UART TX line as a framed byte stream. It sits on the board-level debug path beside the register file and lets the host inspect architectural state without halting the pipeline. Each request captures one coherent snapshot and serialises it as 8N1 bytes with a header and an XOR checksum.

---
 rtl/regfile_dump_uart_if.sv | 26 ++
 rtl/regfile_dump_uart.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_dump_uart_if.sv
// Debug-dump bus: request/snapshot in, serial line and status out.
interface regfile_dump_uart_if;
  logic         dumpReq;
  logic [175:0] regSnapshot;
  logic         txd;
  logic         busy;
  logic         done;

  // Requester side (drives the request and snapshot, watches the line)
  modport master (
    output dumpReq,
    output regSnapshot,
    input  txd,
    input  busy,
    input  done
  );

  // Dumper side
  modport slave (
    input  dumpReq,
    input  regSnapshot,
    output txd,
    output busy,
    output done
  );
endinterface

// File: rtl/regfile_dump_uart.sv
// Serialises a 176-bit register-file snapshot as a 24-byte 8N1 UART frame:
// header, R0..T big-endian per register, then XOR of the 22 data bytes.
module regfile_dump_uart #(
  parameter int          CLKS_PER_BIT = 96,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input logic               CLK,
  input logic               RST,
  regfile_dump_uart_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_BYTE = 5'd23;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [4:0]       byte_idx;
  logic [175:0]     shadow;
  logic [7:0]       checksum;
  logic [7:0]       cur_byte;
  logic [4:0]       reg_sel;
  logic [2:0]       next_bit;

  assign next_bit = bit_idx + 3'd1;
  assign reg_sel  = byte_idx - 5'd1;

  // Byte currently on the wire; checksum is recomputed from the frozen shadow
  always_comb begin
    checksum = 8'h00;
    for (int k = 0; k < 22; k++) checksum = checksum ^ shadow[175 - 8*k -: 8];
    cur_byte = 8'h00;
    if (byte_idx == 5'd0)           cur_byte = HEADER;
    else if (byte_idx == LAST_BYTE) cur_byte = checksum;
    else if (reg_sel < 5'd22)       cur_byte = shadow[175 - 8*int'(reg_sel) -: 8];
  end

  // Frame FSM; txd/busy/done are registered so the line is glitch-free
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 5'd0;
      shadow   <= '0;
      bus.txd  <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.txd  <= 1'b1;
          bus.busy <= 1'b0;
          cnt      <= '0;
          bit_idx  <= 3'd0;
          byte_idx <= 5'd0;
          if (bus.dumpReq) begin
            shadow   <= bus.regSnapshot;
            state    <= START;
            bus.txd  <= 1'b0;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
            bus.txd <= cur_byte[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bus.txd <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              bus.txd <= cur_byte[next_bit];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              // Done cycle doubles as the one mandatory idle gap
              state    <= IDLE;
              byte_idx <= 5'd0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 5'd1;
              state    <= START;
              bus.txd  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
